// File: rtl/bti_demux_ot.sv
// BTI 1-to-N address demultiplexer with an in-order tracking FIFO of up to
// OT_DEPTH outstanding requests; unmapped addresses get a local error response.
module bti_demux_ot #(
  parameter int BTI_AW     = 32,
  parameter int BTI_DW     = 32,
  parameter int BTI_TW     = 4,
  parameter int GST_SEL_AW = 8,
  parameter int GST_NUM    = 4,
  parameter logic [GST_SEL_AW-1:0] GST_SEL [GST_NUM] = '{8'h00, 8'h10, 8'h20, 8'h30},
  parameter int GST_AW [GST_NUM] = '{16, 16, 16, 16},
  parameter int OT_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        host_bti_req_vld_i,
  output logic                        host_bti_req_rdy_o,
  input  logic [BTI_AW-1:0]           host_bti_req_addr_i,
  input  logic [BTI_TW-1:0]           host_bti_req_tid_i,
  output logic                        host_bti_rsp_vld_o,
  input  logic                        host_bti_rsp_rdy_i,
  output logic [BTI_TW-1:0]           host_bti_rsp_tid_o,
  output logic [BTI_DW-1:0]           host_bti_rsp_data_o,
  output logic                        host_bti_rsp_ok_o,
  output logic [GST_NUM-1:0]          gst_bti_req_vld_o,
  input  logic [GST_NUM-1:0]          gst_bti_req_rdy_i,
  output logic [GST_NUM*BTI_AW-1:0]   gst_bti_req_addr_o,
  output logic [GST_NUM*BTI_TW-1:0]   gst_bti_req_tid_o,
  input  logic [GST_NUM-1:0]          gst_bti_rsp_vld_i,
  output logic [GST_NUM-1:0]          gst_bti_rsp_rdy_o,
  input  logic [GST_NUM*BTI_TW-1:0]   gst_bti_rsp_tid_i,
  input  logic [GST_NUM*BTI_DW-1:0]   gst_bti_rsp_data_i,
  input  logic [GST_NUM-1:0]          gst_bti_rsp_ok_i,
  output logic [$clog2(OT_DEPTH+1)-1:0] ot_cnt_o
);

  localparam int IDX_W  = (GST_NUM > 1) ? $clog2(GST_NUM) : 1;
  localparam int PTR_W  = $clog2(OT_DEPTH);
  localparam int CNT_W  = $clog2(OT_DEPTH + 1);
  localparam int WIN_HI = BTI_AW - GST_SEL_AW - 1;

  logic [GST_NUM-1:0] hit_s;
  logic [IDX_W-1:0]   sel_s;
  logic               derr_s;
  logic               gst_rdy_sel_s;
  logic               full_s;
  logic               push_s;
  logic               pop_s;

  logic [IDX_W-1:0]   ent_idx_q [OT_DEPTH];
  logic               ent_err_q [OT_DEPTH];
  logic [BTI_TW-1:0]  ent_tid_q [OT_DEPTH];

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               head_vld_s;
  logic [IDX_W-1:0]   head_idx_s;
  logic               head_err_s;
  logic [BTI_TW-1:0]  head_tid_s;

  // A guest window only checks the address bits between its window width and the select field.
  for (genvar gi = 0; gi < GST_NUM; gi++) begin : g_hit
    localparam int LO = GST_AW[gi];
    logic sel_match_s;
    assign sel_match_s = (host_bti_req_addr_i[BTI_AW-1 -: GST_SEL_AW] == GST_SEL[gi]);
    if (LO <= WIN_HI) begin : g_win
      localparam int WW = WIN_HI - LO + 1;
      assign hit_s[gi] = sel_match_s && (host_bti_req_addr_i[WIN_HI:LO] == {WW{1'b0}});
    end else begin : g_nowin
      assign hit_s[gi] = sel_match_s;
    end
  end

  always_comb begin
    sel_s         = {IDX_W{1'b0}};
    derr_s        = 1'b1;
    gst_rdy_sel_s = 1'b0;
    for (int i = GST_NUM - 1; i >= 0; i--) begin
      sel_s  = hit_s[i] ? IDX_W'(i) : sel_s;
      derr_s = derr_s & ~hit_s[i];
    end
    for (int i = 0; i < GST_NUM; i++) begin
      gst_rdy_sel_s = (sel_s == IDX_W'(i)) ? gst_bti_req_rdy_i[i] : gst_rdy_sel_s;
    end
  end

  // full depends only on the count register, so host_rsp_rdy never reaches host_req_rdy.
  assign full_s             = (cnt_q == CNT_W'(OT_DEPTH));
  assign host_bti_req_rdy_o = ~full_s & (derr_s | gst_rdy_sel_s);
  assign push_s             = host_bti_req_vld_i & host_bti_req_rdy_o;
  assign pop_s              = host_bti_rsp_vld_o & host_bti_rsp_rdy_i;
  assign gst_bti_req_addr_o = {GST_NUM{host_bti_req_addr_i}};
  assign gst_bti_req_tid_o  = {GST_NUM{host_bti_req_tid_i}};

  always_comb begin
    gst_bti_req_vld_o = {GST_NUM{1'b0}};
    for (int i = 0; i < GST_NUM; i++) begin
      gst_bti_req_vld_o[i] = host_bti_req_vld_i & ~full_s & ~derr_s & (sel_s == IDX_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (push_s) begin
      ent_idx_q[wr_ptr_q] <= sel_s;
      ent_err_q[wr_ptr_q] <= derr_s;
      ent_tid_q[wr_ptr_q] <= host_bti_req_tid_i;
    end
  end

  assign head_vld_s = (cnt_q != {CNT_W{1'b0}});
  assign head_idx_s = ent_idx_q[rd_ptr_q];
  assign head_err_s = ent_err_q[rd_ptr_q];
  assign head_tid_s = ent_tid_q[rd_ptr_q];

  // Only the head guest is ever offered rdy; an error head is answered locally.
  always_comb begin
    host_bti_rsp_vld_o  = 1'b0;
    host_bti_rsp_tid_o  = {BTI_TW{1'b0}};
    host_bti_rsp_data_o = {BTI_DW{1'b0}};
    host_bti_rsp_ok_o   = 1'b0;
    gst_bti_rsp_rdy_o   = {GST_NUM{1'b0}};
    if (!head_vld_s) begin
      host_bti_rsp_vld_o = 1'b0;
    end else if (head_err_s) begin
      host_bti_rsp_vld_o = 1'b1;
      host_bti_rsp_tid_o = head_tid_s;
    end else begin
      for (int i = 0; i < GST_NUM; i++) begin
        if (head_idx_s == IDX_W'(i)) begin
          host_bti_rsp_vld_o   = gst_bti_rsp_vld_i[i];
          host_bti_rsp_tid_o   = gst_bti_rsp_tid_i[i*BTI_TW +: BTI_TW];
          host_bti_rsp_data_o  = gst_bti_rsp_data_i[i*BTI_DW +: BTI_DW];
          host_bti_rsp_ok_o    = gst_bti_rsp_ok_i[i];
          gst_bti_rsp_rdy_o[i] = host_bti_rsp_rdy_i;
        end else begin
          gst_bti_rsp_rdy_o[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    wr_ptr_d = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ot_cnt_o = cnt_q;

endmodule

// File: tb/tb_bti_demux_ot.sv
// Scoreboard bench for bti_demux_ot: host expectations are queued on request
// acceptance and compared in order against host responses.
module tb_bti_demux_ot;

  localparam int NG = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              host_bti_req_vld_i;
  logic              host_bti_req_rdy_o;
  logic [31:0]       host_bti_req_addr_i;
  logic [3:0]        host_bti_req_tid_i;
  logic              host_bti_rsp_vld_o;
  logic              host_bti_rsp_rdy_i;
  logic [3:0]        host_bti_rsp_tid_o;
  logic [31:0]       host_bti_rsp_data_o;
  logic              host_bti_rsp_ok_o;
  logic [NG-1:0]     gst_bti_req_vld_o;
  logic [NG-1:0]     gst_bti_req_rdy_i;
  logic [NG*32-1:0]  gst_bti_req_addr_o;
  logic [NG*4-1:0]   gst_bti_req_tid_o;
  logic [NG-1:0]     gst_bti_rsp_vld_i;
  logic [NG-1:0]     gst_bti_rsp_rdy_o;
  logic [NG*4-1:0]   gst_bti_rsp_tid_i;
  logic [NG*32-1:0]  gst_bti_rsp_data_i;
  logic [NG-1:0]     gst_bti_rsp_ok_i;
  logic [2:0]        ot_cnt_o;

  bti_demux_ot #(
    .BTI_AW(32), .BTI_DW(32), .BTI_TW(4), .GST_SEL_AW(8), .GST_NUM(NG),
    .GST_SEL('{8'h00, 8'h10, 8'h20, 8'h30}), .GST_AW('{16, 16, 16, 16}), .OT_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .host_bti_req_vld_i(host_bti_req_vld_i), .host_bti_req_rdy_o(host_bti_req_rdy_o),
    .host_bti_req_addr_i(host_bti_req_addr_i), .host_bti_req_tid_i(host_bti_req_tid_i),
    .host_bti_rsp_vld_o(host_bti_rsp_vld_o), .host_bti_rsp_rdy_i(host_bti_rsp_rdy_i),
    .host_bti_rsp_tid_o(host_bti_rsp_tid_o), .host_bti_rsp_data_o(host_bti_rsp_data_o),
    .host_bti_rsp_ok_o(host_bti_rsp_ok_o),
    .gst_bti_req_vld_o(gst_bti_req_vld_o), .gst_bti_req_rdy_i(gst_bti_req_rdy_i),
    .gst_bti_req_addr_o(gst_bti_req_addr_o), .gst_bti_req_tid_o(gst_bti_req_tid_o),
    .gst_bti_rsp_vld_i(gst_bti_rsp_vld_i), .gst_bti_rsp_rdy_o(gst_bti_rsp_rdy_o),
    .gst_bti_rsp_tid_i(gst_bti_rsp_tid_i), .gst_bti_rsp_data_i(gst_bti_rsp_data_i),
    .gst_bti_rsp_ok_i(gst_bti_rsp_ok_i), .ot_cnt_o(ot_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  tid;
    logic [31:0] data;
    logic        ok;
  } exp_t;

  exp_t        sb [$];
  logic [3:0]  gq [NG][$];
  int          credit [NG];
  logic [31:0] gdata [16];
  int          checks = 0;
  int          failures = 0;

  // Reference decode: top byte selects guest 0x00/0x10/0x20/0x30, bits [23:16] must be zero.
  function automatic int exp_guest(input logic [31:0] a);
    if (a[23:16] != 8'h00) return -1;
    case (a[31:24])
      8'h00: return 0;
      8'h10: return 1;
      8'h20: return 2;
      8'h30: return 3;
      default: return -1;
    endcase
  endfunction

  // Behavioural guests: capture accepted tids, answer in acceptance order while credit lasts.
  initial begin
    logic [NG-1:0] rq_hs, rs_hs;
    logic [3:0]    rq_tid [NG];
    logic          in_rst;
    gst_bti_rsp_vld_i  = '0;
    gst_bti_rsp_tid_i  = '0;
    gst_bti_rsp_data_i = '0;
    gst_bti_rsp_ok_i   = '0;
    for (int g = 0; g < NG; g++) credit[g] = 0;
    forever begin
      @(negedge clk);
      in_rst = rst;
      for (int g = 0; g < NG; g++) begin
        rq_hs[g]  = gst_bti_req_vld_o[g] & gst_bti_req_rdy_i[g];
        rs_hs[g]  = gst_bti_rsp_vld_i[g] & gst_bti_rsp_rdy_o[g];
        rq_tid[g] = gst_bti_req_tid_o[g*4 +: 4];
      end
      @(posedge clk); #1;
      for (int g = 0; g < NG; g++) begin
        if (!in_rst && rq_hs[g]) gq[g].push_back(rq_tid[g]);
        if (!in_rst && rs_hs[g] && gq[g].size() > 0) begin
          void'(gq[g].pop_front());
          credit[g] = credit[g] - 1;
        end
        gst_bti_rsp_vld_i[g] = (credit[g] > 0) && (gq[g].size() > 0);
        gst_bti_rsp_tid_i[g*4 +: 4]   = (gq[g].size() > 0) ? gq[g][0] : 4'h0;
        gst_bti_rsp_data_i[g*32 +: 32] = (gq[g].size() > 0) ? gdata[gq[g][0]] : 32'h0;
        gst_bti_rsp_ok_i[g] = 1'b1;
      end
    end
  end

  // Host response monitor: every host handshake pops and compares the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (host_bti_rsp_vld_o && host_bti_rsp_rdy_i) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL rsp_unexpected got tid=%0h data=%h ok=%0b required=no response",
                   host_bti_rsp_tid_o, host_bti_rsp_data_o, host_bti_rsp_ok_o);
        end else begin
          e = sb.pop_front();
          if ({host_bti_rsp_tid_o, host_bti_rsp_data_o, host_bti_rsp_ok_o} !== {e.tid, e.data, e.ok}) begin
            failures++;
            $display("FAIL rsp_order got tid=%0h data=%h ok=%0b required tid=%0h data=%h ok=%0b",
                     host_bti_rsp_tid_o, host_bti_rsp_data_o, host_bti_rsp_ok_o, e.tid, e.data, e.ok);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [3:0] t);
    int   g, n;
    logic acc;
    exp_t e;
    logic [NG-1:0] ev;
    g = exp_guest(a);
    ev = (g < 0) ? 4'b0000 : (4'b0001 << g);
    host_bti_req_vld_i  = 1'b1;
    host_bti_req_addr_i = a;
    host_bti_req_tid_i  = t;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      if (host_bti_req_rdy_o) begin
        acc = 1'b1;
        checks++;
        if (gst_bti_req_vld_o !== ev) begin
          failures++;
          $display("FAIL req_route addr=%h got vld=%b required=%b", a, gst_bti_req_vld_o, ev);
        end
        e.tid  = t;
        e.data = (g < 0) ? 32'h0 : gdata[t];
        e.ok   = (g < 0) ? 1'b0 : 1'b1;
        sb.push_back(e);
      end
      tick();
      n++;
    end
    host_bti_req_vld_i = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL req_accept_timeout addr=%h got rdy=0 required=1", a);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout got pending=%0d required=0", sb.size());
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    host_bti_req_vld_i  = 1'b1;
    host_bti_req_addr_i = 32'h1000_0000;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if (ot_cnt_o !== 3'd0 || host_bti_rsp_vld_o !== 1'b0 || gst_bti_rsp_rdy_o !== 4'b0000 ||
        host_bti_rsp_data_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_state got cnt=%0d rvld=%0b grdy=%b data=%h required 0/0/0000/0",
               ot_cnt_o, host_bti_rsp_vld_o, gst_bti_rsp_rdy_o, host_bti_rsp_data_o);
    end
    checks++;
    if (gst_bti_req_vld_o !== 4'b0010) begin
      failures++;
      $display("FAIL reset_gst_vld got %b required 0010", gst_bti_req_vld_o);
    end
    tick();
    host_bti_req_vld_i = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    send(32'h1000_0004, 4'd3);
    @(negedge clk);
    checks++;
    if (ot_cnt_o !== 3'd1) begin
      failures++;
      $display("FAIL single_cnt got %0d required 1", ot_cnt_o);
    end
    tick();
    credit[1] = 1;
    wait_drain();
    @(negedge clk);
    checks++;
    if (ot_cnt_o !== 3'd0) begin
      failures++;
      $display("FAIL single_cnt_end got %0d required 0", ot_cnt_o);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int order [4] = '{3, 1, 0, 2};
    send(32'h2000_0000, 4'd0);
    send(32'h0000_0000, 4'd1);
    send(32'h1000_0000, 4'd2);
    send(32'h3000_0000, 4'd3);
    host_bti_req_vld_i  = 1'b1;
    host_bti_req_addr_i = 32'h0000_0100;
    host_bti_req_tid_i  = 4'hF;
    @(negedge clk);
    checks++;
    if (ot_cnt_o !== 3'd4 || host_bti_req_rdy_o !== 1'b0) begin
      failures++;
      $display("FAIL b2b_full got cnt=%0d rdy=%0b required cnt=4 rdy=0", ot_cnt_o, host_bti_req_rdy_o);
    end
    tick();
    host_bti_req_vld_i = 1'b0;
    foreach (order[k]) begin
      credit[order[k]] = 1;
      repeat (2) tick();
      if (k == 0) begin
        @(negedge clk);
        checks++;
        if (gst_bti_rsp_rdy_o[3] !== 1'b0 || sb.size() != 4) begin
          failures++;
          $display("FAIL b2b_nonhead got rdy3=%0b pending=%0d required 0/4", gst_bti_rsp_rdy_o[3], sb.size());
        end
        tick();
      end
    end
    wait_drain();
  endtask

  task automatic test_decode_err();
    logic [31:0] addrs [3] = '{32'h1001_0000, 32'h4000_0000, 32'h0080_0000};
    logic [3:0]  tids  [3] = '{4'd7, 4'd8, 4'd9};
    foreach (addrs[k]) begin
      send(addrs[k], tids[k]);
      @(negedge clk);
      checks++;
      if (host_bti_rsp_vld_o !== 1'b1 || host_bti_rsp_tid_o !== tids[k] ||
          host_bti_rsp_ok_o !== 1'b0 || host_bti_rsp_data_o !== 32'h0) begin
        failures++;
        $display("FAIL derr_latency got vld=%0b tid=%0h ok=%0b data=%h required 1/%0h/0/0",
                 host_bti_rsp_vld_o, host_bti_rsp_tid_o, host_bti_rsp_ok_o, host_bti_rsp_data_o, tids[k]);
      end
      tick();
    end
    wait_drain();
  endtask

  task automatic test_full_pop();
    int   n;
    exp_t e;
    for (int t = 0; t < 4; t++) send(32'h0000_0010, 4'(t));
    host_bti_req_vld_i  = 1'b1;
    host_bti_req_addr_i = 32'h1000_0020;
    host_bti_req_tid_i  = 4'd4;
    credit[0] = 1;
    n = 0;
    @(negedge clk);
    while (!(host_bti_rsp_vld_o && host_bti_rsp_rdy_i) && n < 20) begin
      tick();
      @(negedge clk);
      n++;
    end
    checks++;
    if (ot_cnt_o !== 3'd4 || host_bti_req_rdy_o !== 1'b0) begin
      failures++;
      $display("FAIL full_pop_block got cnt=%0d rdy=%0b required 4/0", ot_cnt_o, host_bti_req_rdy_o);
    end
    tick();
    @(negedge clk);
    checks++;
    if (ot_cnt_o !== 3'd3 || host_bti_req_rdy_o !== 1'b1) begin
      failures++;
      $display("FAIL full_pop_accept got cnt=%0d rdy=%0b required 3/1", ot_cnt_o, host_bti_req_rdy_o);
    end else begin
      e.tid = 4'd4; e.data = gdata[4]; e.ok = 1'b1;
      sb.push_back(e);
    end
    tick();
    host_bti_req_vld_i = 1'b0;
    @(negedge clk);
    checks++;
    if (ot_cnt_o !== 3'd4) begin
      failures++;
      $display("FAIL full_pop_refill got cnt=%0d required 4", ot_cnt_o);
    end
    tick();
    credit[0] = 3;
    credit[1] = 1;
    wait_drain();
  endtask

  task automatic test_backpressure();
    send(32'h0000_0000, 4'd9);
    send(32'h1000_0000, 4'd10);
    host_bti_rsp_rdy_i = 1'b0;
    credit[0] = 1;
    credit[1] = 1;
    repeat (2) tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (gst_bti_rsp_rdy_o !== 4'b0000 || host_bti_rsp_vld_o !== 1'b1 ||
          host_bti_rsp_tid_o !== 4'd9 || host_bti_rsp_data_o !== gdata[9]) begin
        failures++;
        $display("FAIL backpressure got grdy=%b vld=%0b tid=%0h data=%h required 0000/1/9/%h",
                 gst_bti_rsp_rdy_o, host_bti_rsp_vld_o, host_bti_rsp_tid_o, host_bti_rsp_data_o, gdata[9]);
      end
      tick();
    end
    host_bti_rsp_rdy_i = 1'b1;
    wait_drain();
  endtask

  task automatic test_reset_mid();
    send(32'h2000_0000, 4'd5);
    send(32'h3000_0000, 4'd6);
    @(negedge clk);
    checks++;
    if (ot_cnt_o !== 3'd2) begin
      failures++;
      $display("FAIL mid_cnt got %0d required 2", ot_cnt_o);
    end
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (ot_cnt_o !== 3'd0 || host_bti_rsp_vld_o !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got cnt=%0d vld=%0b required 0/0", ot_cnt_o, host_bti_rsp_vld_o);
    end
    sb.delete();
    repeat (2) tick();
    rst = 1'b0;
    credit[2] = 5;
    credit[3] = 5;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (host_bti_rsp_vld_o !== 1'b0 || gst_bti_rsp_rdy_o !== 4'b0000) begin
        failures++;
        $display("FAIL late_rsp got vld=%0b grdy=%b required 0/0000", host_bti_rsp_vld_o, gst_bti_rsp_rdy_o);
      end
      tick();
    end
    for (int g = 0; g < NG; g++) begin
      credit[g] = 0;
      gq[g].delete();
    end
    repeat (2) tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) gdata[i] = 32'hC0DE_0000 + i * 32'h0000_0101;
    gdata[3] = 32'hDEAD_BEEF;
    rst = 1'b1;
    host_bti_req_vld_i  = 1'b0;
    host_bti_req_addr_i = 32'h0;
    host_bti_req_tid_i  = 4'h0;
    host_bti_rsp_rdy_i  = 1'b1;
    gst_bti_req_rdy_i   = 4'b1111;
    test_reset();
    test_single();
    test_back_to_back();
    test_decode_err();
    test_full_pop();
    test_backpressure();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL final_pending got %0d required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
